display_scan_ctrl: RTL and testbench

DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

---
 rtl/display_pkg.sv | 25 ++
 rtl/down_counter.sv | 49 ++++
 rtl/display_scan_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_display_scan_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared definitions for the seven-segment display scan controller.
//
// Contents:
//   scan_state_e          - scan FSM states (IDLE, BLANK, SHOW)
//   DEFAULT_NUM_DIGITS    - default number of multiplexed digits
//   DEFAULT_DWELL_CYCLES  - default lit time per digit at 48 MHz (80 Hz toggle)
//   DEFAULT_BLANK_CYCLES  - default dark time before each digit at 48 MHz
//   max_int               - helper used to size the shared dwell/blank counter
package display_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } scan_state_e;

    localparam int DEFAULT_NUM_DIGITS   = 2;
    localparam int DEFAULT_DWELL_CYCLES = 300000;
    localparam int DEFAULT_BLANK_CYCLES = 4800;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/down_counter.sv
// Loadable down counter with a terminal-count flag.
//
// Ports:
//   clk       - clock
//   rst_n     - asynchronous active-low reset (clears the count)
//   clear     - synchronous clear to zero (wins over load)
//   load      - synchronous load of load_val
//   load_val  - value loaded when load is high
//   tc        - high while the count equals 1, i.e. on the last cycle of a
//               loaded interval; a load of N therefore spans N cycles
module down_counter
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             tc
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // The count parks at zero once exhausted so an unloaded counter never
    // raises tc spuriously.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == WIDTH'(1));

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for a bank of seven-segment digits.
// Each digit is preceded by a dark (blank) interval and then lit for a dwell
// interval; the nibble to display is taken from a snapshot of digits_in that
// is refreshed only at the start of each frame. The segment decoder lives
// outside this block and is fed from hex_out.
//
// Ports:
//   clk         - system clock
//   reset       - asynchronous active-low reset; release is synchronized
//   en          - scan enable, level-sensitive; low forces IDLE
//   digits_in   - packed hex digits, digit i in bits [4i+3:4i]
//   hex_out     - registered nibble for the current digit
//   digit_sel   - registered index of the current digit
//   an_n        - registered active-low digit enables, at most one low
//   frame_done  - registered one-cycle pulse after the last digit's dwell
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int NUM_DIGITS   = DEFAULT_NUM_DIGITS,
    parameter int DWELL_CYCLES = DEFAULT_DWELL_CYCLES,
    parameter int BLANK_CYCLES = DEFAULT_BLANK_CYCLES
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic [4*NUM_DIGITS-1:0]       digits_in,
    output logic [3:0]                    hex_out,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_sel,
    output logic [NUM_DIGITS-1:0]         an_n,
    output logic                          frame_done
);

    localparam int SEL_W = $clog2(NUM_DIGITS);
    localparam int CNT_W = $clog2(max_int(DWELL_CYCLES, BLANK_CYCLES) + 1);

    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES);
    localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES);
    localparam logic [SEL_W-1:0] LAST_DIGIT = SEL_W'(NUM_DIGITS - 1);

    // With no blank interval, every digit entry goes straight to SHOW.
    localparam scan_state_e      ENTRY_STATE = (BLANK_CYCLES == 0) ? SHOW : BLANK;
    localparam logic [CNT_W-1:0] ENTRY_LOAD  = (BLANK_CYCLES == 0) ? DWELL_LOAD : BLANK_LOAD;

    // Reset synchronizer: assertion is immediate, release takes two edges.
    logic rst_meta_q;
    logic rst_sync_n_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_meta_q   <= 1'b0;
            rst_sync_n_q <= 1'b0;
        end else begin
            rst_meta_q   <= 1'b1;
            rst_sync_n_q <= rst_meta_q;
        end
    end

    scan_state_e             state_q, state_d;
    logic [SEL_W-1:0]        digit_q, digit_d;
    logic [SEL_W-1:0]        digit_inc;
    logic [3:0]              hex_q, hex_d;
    logic [NUM_DIGITS-1:0]   an_n_q, an_n_d;
    logic                    frame_done_q, frame_done_d;
    logic [4*NUM_DIGITS-1:0] snapshot_q, snapshot_d;
    logic [3:0]              snap_nibble [NUM_DIGITS];

    logic             cnt_clear;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_tc;

    down_counter #(
        .WIDTH (CNT_W)
    ) u_counter (
        .clk      (clk),
        .rst_n    (rst_sync_n_q),
        .clear    (cnt_clear),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .tc       (cnt_tc)
    );

    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            snap_nibble[i] = snapshot_q[4*i +: 4];
        end
    end

    assign digit_inc = digit_q + SEL_W'(1);

    // Next-state logic. Dropping en always wins, including on the wrap edge,
    // so an aborted frame never reports frame_done. A new snapshot is taken
    // whenever digit 0 is (re)entered, and hex_d is fed from the incoming
    // data directly so hex_out changes on the same edge as digit_sel.
    always_comb begin
        state_d      = state_q;
        digit_d      = digit_q;
        hex_d        = hex_q;
        snapshot_d   = snapshot_q;
        frame_done_d = 1'b0;
        cnt_clear    = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = ENTRY_LOAD;

        unique case (state_q)
            IDLE: begin
                if (en) begin
                    state_d      = ENTRY_STATE;
                    cnt_load     = 1'b1;
                    cnt_load_val = ENTRY_LOAD;
                    snapshot_d   = digits_in;
                    digit_d      = '0;
                    hex_d        = digits_in[3:0];
                end else begin
                    cnt_clear = 1'b1;
                    digit_d   = '0;
                    hex_d     = '0;
                end
            end
            BLANK: begin
                if (!en) begin
                    state_d   = IDLE;
                    cnt_clear = 1'b1;
                    digit_d   = '0;
                    hex_d     = '0;
                end else if (cnt_tc) begin
                    state_d      = SHOW;
                    cnt_load     = 1'b1;
                    cnt_load_val = DWELL_LOAD;
                end
            end
            SHOW: begin
                if (!en) begin
                    state_d   = IDLE;
                    cnt_clear = 1'b1;
                    digit_d   = '0;
                    hex_d     = '0;
                end else if (cnt_tc) begin
                    state_d      = ENTRY_STATE;
                    cnt_load     = 1'b1;
                    cnt_load_val = ENTRY_LOAD;
                    if (digit_q == LAST_DIGIT) begin
                        frame_done_d = 1'b1;
                        snapshot_d   = digits_in;
                        digit_d      = '0;
                        hex_d        = digits_in[3:0];
                    end else begin
                        digit_d = digit_inc;
                        hex_d   = snap_nibble[digit_inc];
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                cnt_clear = 1'b1;
                digit_d   = '0;
                hex_d     = '0;
            end
        endcase

        // Anode enables follow the next state so they are glitch-free flops.
        for (int i = 0; i < NUM_DIGITS; i++) begin
            an_n_d[i] = !((state_d == SHOW) && (digit_d == SEL_W'(i)));
        end
    end

    always_ff @(posedge clk or negedge rst_sync_n_q) begin
        if (!rst_sync_n_q) begin
            state_q      <= IDLE;
            digit_q      <= '0;
            hex_q        <= '0;
            an_n_q       <= '1;
            frame_done_q <= 1'b0;
            snapshot_q   <= '0;
        end else begin
            state_q      <= state_d;
            digit_q      <= digit_d;
            hex_q        <= hex_d;
            an_n_q       <= an_n_d;
            frame_done_q <= frame_done_d;
            snapshot_q   <= snapshot_d;
        end
    end

    assign hex_out    = hex_q;
    assign digit_sel  = digit_q;
    assign an_n       = an_n_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl: two instances, one with a 2-cycle
// blank and one with no blank, both with 2 digits and a 4-cycle dwell.
// Stimulus pushes the expected per-cycle outputs into a queue; a monitor per
// instance pops one entry each cycle and compares.
module tb_display_scan_ctrl;

    typedef struct packed {
        logic [1:0] an;
        logic [3:0] hex;
        logic       sel;
        logic       fd;
    } exp_t;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset     = 1'b1;
    logic       en        = 1'b0;
    logic [7:0] digits_in = 8'h3A;
    logic [3:0] hex_out;
    logic [0:0] digit_sel;
    logic [1:0] an_n;
    logic       frame_done;

    logic       reset_zb     = 1'b1;
    logic       en_zb        = 1'b0;
    logic [7:0] digits_in_zb = 8'h3A;
    logic [3:0] hex_out_zb;
    logic [0:0] digit_sel_zb;
    logic [1:0] an_n_zb;
    logic       frame_done_zb;

    exp_t q_main[$];
    exp_t q_zb[$];
    exp_t e_main;
    exp_t e_zb;
    int   checks   = 0;
    int   failures = 0;
    bit   mon_on   = 1'b0;

    display_scan_ctrl #(
        .NUM_DIGITS   (2),
        .DWELL_CYCLES (4),
        .BLANK_CYCLES (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .digits_in  (digits_in),
        .hex_out    (hex_out),
        .digit_sel  (digit_sel),
        .an_n       (an_n),
        .frame_done (frame_done)
    );

    display_scan_ctrl #(
        .NUM_DIGITS   (2),
        .DWELL_CYCLES (4),
        .BLANK_CYCLES (0)
    ) dut_zb (
        .clk        (clk),
        .reset      (reset_zb),
        .en         (en_zb),
        .digits_in  (digits_in_zb),
        .hex_out    (hex_out_zb),
        .digit_sel  (digit_sel_zb),
        .an_n       (an_n_zb),
        .frame_done (frame_done_zb)
    );

    task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h time=%0t", name, act, req, $time);
        end
    endtask

    task automatic push_phase(input int which, input logic [1:0] an, input logic [3:0] hex,
                              input logic sel, input logic fd_first, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.an  = an;
            e.hex = hex;
            e.sel = sel;
            e.fd  = (i == 0) ? fd_first : 1'b0;
            if (which == 0) q_main.push_back(e);
            else            q_zb.push_back(e);
        end
    endtask

    // One full frame of two digits; the first cycle carries frame_done unless
    // this is the first frame after leaving IDLE.
    task automatic push_frame(input int which, input logic [3:0] lo, input logic [3:0] hi,
                              input bit first, input int blank);
        if (blank > 0) begin
            push_phase(which, 2'b11, lo, 1'b0, !first, blank);
            push_phase(which, 2'b10, lo, 1'b0, 1'b0, 4);
            push_phase(which, 2'b11, hi, 1'b1, 1'b0, blank);
        end else begin
            push_phase(which, 2'b10, lo, 1'b0, !first, 4);
        end
        push_phase(which, 2'b01, hi, 1'b1, 1'b0, 4);
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_main(input string tag);
        check_output({tag, "_an_n"},       {6'd0, an_n},       8'h03);
        check_output({tag, "_hex_out"},    {4'd0, hex_out},    8'h00);
        check_output({tag, "_digit_sel"},  {7'd0, digit_sel},  8'h00);
        check_output({tag, "_frame_done"}, {7'd0, frame_done}, 8'h00);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((q_main.size() != 0 || q_zb.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_output(name, 8'(q_main.size() + q_zb.size()), 8'd0);
    endtask

    // Main-instance monitor: one expected entry per cycle while queued.
    always @(posedge clk) begin
        #1;
        if (mon_on) begin
            check_output("onehot_main", {7'd0, ($countones(~an_n) > 1)}, 8'd0);
            if (q_main.size() > 0) begin
                e_main = q_main.pop_front();
                check_output("main_an_n",       {6'd0, an_n},       {6'd0, e_main.an});
                check_output("main_hex_out",    {4'd0, hex_out},    {4'd0, e_main.hex});
                check_output("main_digit_sel",  {7'd0, digit_sel},  {7'd0, e_main.sel});
                check_output("main_frame_done", {7'd0, frame_done}, {7'd0, e_main.fd});
            end
        end
    end

    // Zero-blank-instance monitor.
    always @(posedge clk) begin
        #1;
        if (mon_on) begin
            check_output("onehot_zb", {7'd0, ($countones(~an_n_zb) > 1)}, 8'd0);
            if (q_zb.size() > 0) begin
                e_zb = q_zb.pop_front();
                check_output("zb_an_n",       {6'd0, an_n_zb},       {6'd0, e_zb.an});
                check_output("zb_hex_out",    {4'd0, hex_out_zb},    {4'd0, e_zb.hex});
                check_output("zb_digit_sel",  {7'd0, digit_sel_zb},  {7'd0, e_zb.sel});
                check_output("zb_frame_done", {7'd0, frame_done_zb}, {7'd0, e_zb.fd});
            end
        end
    end

    initial begin
        wait_neg(3);
        reset    = 1'b0;
        reset_zb = 1'b0;
        #1;
        mon_on = 1'b1;
        check_reset_main("reset");
        wait_neg(2);
        reset = 1'b1;
        wait_neg(3);
        check_reset_main("idle");

        // Three frames of 3A; digits_in switches to 5C during the third
        // frame's digit-1 dwell, en drops in dwell cycle 2 of the fourth
        // frame's digit 0, then the scan restarts and is hit by reset.
        push_frame(0, 4'hA, 4'h3, 1'b1, 2);
        push_frame(0, 4'hA, 4'h3, 1'b0, 2);
        push_frame(0, 4'hA, 4'h3, 1'b0, 2);
        push_phase(0, 2'b11, 4'hC, 1'b0, 1'b1, 2);
        push_phase(0, 2'b10, 4'hC, 1'b0, 1'b0, 2);
        push_phase(0, 2'b11, 4'h0, 1'b0, 1'b0, 3);
        push_phase(0, 2'b11, 4'hC, 1'b0, 1'b0, 2);
        push_phase(0, 2'b10, 4'hC, 1'b0, 1'b0, 4);
        push_phase(0, 2'b11, 4'h5, 1'b1, 1'b0, 2);
        push_phase(0, 2'b01, 4'h5, 1'b1, 1'b0, 2);
        en = 1'b1;
        wait_neg(33);
        digits_in = 8'h5C;
        wait_neg(7);
        en = 1'b0;
        wait_neg(3);
        en = 1'b1;
        wait_neg(10);

        // Asynchronous reset in the middle of digit 1's dwell.
        reset = 1'b0;
        #1;
        check_reset_main("async_reset");
        en = 1'b0;
        wait_neg(2);
        check_reset_main("held_reset");
        reset = 1'b1;
        wait_neg(3);

        digits_in = 8'h7E;
        push_frame(0, 4'hE, 4'h7, 1'b1, 2);
        push_phase(0, 2'b11, 4'hE, 1'b0, 1'b1, 1);
        en = 1'b1;
        wait_neg(13);
        en = 1'b0;
        wait_drain("drain_main");

        // Zero-blank instance: en drops exactly on the wrap edge, so the
        // scan goes idle without a frame_done pulse.
        reset_zb = 1'b1;
        wait_neg(3);
        push_frame(1, 4'hA, 4'h3, 1'b1, 0);
        push_frame(1, 4'hA, 4'h3, 1'b0, 0);
        push_phase(1, 2'b11, 4'h0, 1'b0, 1'b0, 1);
        en_zb = 1'b1;
        wait_neg(16);
        en_zb = 1'b0;
        wait_drain("drain_zb");
        wait_neg(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
